cache_mem_arbiter: RTL and testbench

Sits directly downstream of every cache_control memory port (mem_address/mem_read/mem_write/mem_writedata/mem_readdata/mem_waitrequest). It arbitrates line-wide requests from N cache nodes and serializes each 128-bit line into four 32-bit beats on a single word-wide Avalon-MM master port toward the system interconnect. From each cache's point of view it is a slave that holds waitrequest high until the full line transfer is done.

---
 rtl/cache_mem_arbiter_pkg.sv | 21 ++
 rtl/cache_mem_rr_arbiter.sv | 42 ++++
 rtl/cache_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
//   Shared types for the cache-to-memory line arbiter: word/line data types,
//   beat counter type, line geometry and the arbiter FSM state encoding.
//   No ports (package).
package cache_mem_arbiter_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int LINE_WORDS = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [1:0]        mem_beat;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state;

endpackage

// File: rtl/cache_mem_rr_arbiter.sv
// cache_mem_rr_arbiter
//   Combinational grant selection among N cache requesters.
//   Default: round-robin, first requester at index >= ptr, wrapping mod N.
//   With CACHE_MEM_ARB_FIXED_PRIO_EN defined: lowest-index requester wins
//   and the ptr port does not exist.
// Ports:
//   req        in   N   request vector
//   ptr        in   IW  round-robin start index (round-robin build only)
//   gnt_valid  out  1   at least one request present
//   gnt_idx    out  IW  index of the granted requester
module cache_mem_rr_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr) + k) % N;
`endif
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Arbitrates 128-bit line requests from N caches and serialises each line
//   into four 32-bit beats on one Avalon-MM master port. Each cache sees a
//   slave that holds waitrequest until its whole line has moved.
//   Optional macro CACHE_MEM_ARB_FIXED_PRIO_EN: fixed lowest-index priority
//   instead of round-robin (bring-up/debug only, may starve).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cache_address[N]         line address per cache, bits [3:0] ignored
//   cache_read/cache_write   per-cache line requests (read wins if both)
//   cache_writedata[N]       line to write per cache
//   cache_waitrequest[N]     low for one cycle for the granted cache at end
//   cache_readdata           assembled read line, shared by all caches
//   mem_*                    word-wide Avalon-MM master toward interconnect
//
// state | meaning
// IDLE  | no transfer; evaluate requests and grant
// XFER  | moving beat 0..3 of the granted line
// DONE  | line complete; granted cache sees waitrequest low
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][31:0]   cache_address,
  input  logic [N-1:0]         cache_read,
  input  logic [N-1:0]         cache_write,
  input  logic [N-1:0][127:0]  cache_writedata,
  output logic [N-1:0]         cache_waitrequest,
  output logic [127:0]         cache_readdata,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_writedata,
  output logic [3:0]           mem_byteenable,
  input  logic [31:0]          mem_readdata,
  input  logic                 mem_waitrequest
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state      state;
  mem_beat       beat;
  logic [IW-1:0] gnt_q;
  logic [27:0]   base_q;
  logic          rd_q;
  line_t         wline_q;
  line_t         rline_q;

  logic [N-1:0]  req;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  assign req = cache_read | cache_write;

`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr;
`endif

  cache_mem_rr_arbiter #(.N(N)) u_arb (
    .req       (req),
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
    .ptr       (ptr),
`endif
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Read and write lines are buffered separately so a write transfer does
  // not disturb the last assembled read line seen on cache_readdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q   <= gnt_idx;
            base_q  <= cache_address[gnt_idx][31:4];
            wline_q <= cache_writedata[gnt_idx];
            rd_q    <= cache_read[gnt_idx];
            beat    <= '0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (!mem_waitrequest) begin
            if (rd_q) rline_q[{beat, 5'd0} +: 32] <= mem_readdata;
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= DONE;
          end
        end
        DONE: begin
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
          ptr <= (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read       = (state == XFER) && rd_q;
  assign mem_write      = (state == XFER) && !rd_q;
  assign mem_address    = {base_q, beat, 2'b00};
  assign mem_writedata  = wline_q[{beat, 5'd0} +: 32];
  assign mem_byteenable = {4{state == XFER}};
  assign cache_readdata = rline_q;

  always_comb begin
    cache_waitrequest = '1;
    if (state == DONE) cache_waitrequest[gnt_q] = 1'b0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0][31:0]   cache_address;
  logic [3:0]         cache_read;
  logic [3:0]         cache_write;
  logic [3:0][127:0]  cache_writedata;
  logic [3:0]         cache_waitrequest;
  logic [127:0]       cache_readdata;
  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_writedata;
  logic [3:0]         mem_byteenable;
  logic [31:0]        mem_readdata;
  logic               mem_waitrequest;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory returns 0xA,0xB,0xC,0xD for word 0..3 of any line.
  assign mem_readdata = 32'hA + {30'b0, mem_address[3:2]};

  cache_mem_arbiter #(.N(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .cache_address     (cache_address),
    .cache_read        (cache_read),
    .cache_write       (cache_write),
    .cache_writedata   (cache_writedata),
    .cache_waitrequest (cache_waitrequest),
    .cache_readdata    (cache_readdata),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_readdata      (mem_readdata),
    .mem_waitrequest   (mem_waitrequest)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        stall;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_wreq;
  } vec_t;

  localparam logic [127:0] RD_LINE = 128'h0000000D_0000000C_0000000B_0000000A;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_read"}, mem_read, 1'b0);
    chk({tag, "_mem_write"}, mem_write, 1'b0);
    chk({tag, "_wreq"}, cache_waitrequest, 4'hF);
    chk({tag, "_be"}, mem_byteenable, 4'h0);
  endtask

  // Steps until cache idx sees waitrequest low; returns steps taken.
  task automatic wait_done(input int idx, output int steps);
    steps = 0;
    while (cache_waitrequest[idx] && steps < 20) begin
      step();
      steps++;
    end
  endtask

  initial begin
    int steps;
    int g;
    int exp_g[6];

    // cache1 read 0x1230, no stalls: done at cycle 6
    vecs[0]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF};
    vecs[1]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h1230, 32'h0,        4'hF};
    vecs[2]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0,        4'hF};
    vecs[3]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h1238, 32'h0,        4'hF};
    vecs[4]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h123C, 32'h0,        4'hF};
    vecs[5]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'b1101};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF};
    // cache0 write 0x2000, beat 1 stalled 2 cycles: done at cycle 8
    vecs[7]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF};
    vecs[8]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h11111111, 4'hF};
    vecs[9]  = '{4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 32'h2004, 32'h22222222, 4'hF};
    vecs[10] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 32'h2004, 32'h22222222, 4'hF};
    vecs[11] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h2004, 32'h22222222, 4'hF};
    vecs[12] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h2008, 32'h33333333, 4'hF};
    vecs[13] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h200C, 32'h44444444, 4'hF};
    vecs[14] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'b1110};
    vecs[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF};

`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0, 0};
`else
    exp_g = '{0, 2, 3, 0, 2, 3};
`endif

    rst             = 1'b1;
    cache_address   = '0;
    cache_read      = '0;
    cache_write     = '0;
    cache_writedata = '0;
    mem_waitrequest = 1'b0;
    cache_address[1]   = 32'h0000_1230;
    cache_address[0]   = 32'h0000_2000;
    cache_writedata[0] = 128'h44444444_33333333_22222222_11111111;
    step();
    step();
    rst = 1'b0;
    chk_idle_outputs("reset");

    for (int i = 0; i < 16; i++) begin
      cache_read      = vecs[i].rd;
      cache_write     = vecs[i].wr;
      mem_waitrequest = vecs[i].stall;
      #1;
      chk($sformatf("row%0d_mem_read", i), mem_read, vecs[i].exp_rd);
      chk($sformatf("row%0d_mem_write", i), mem_write, vecs[i].exp_wr);
      chk($sformatf("row%0d_wreq", i), cache_waitrequest, vecs[i].exp_wreq);
      chk($sformatf("row%0d_be", i), mem_byteenable,
          (vecs[i].exp_rd || vecs[i].exp_wr) ? 4'hF : 4'h0);
      if (vecs[i].exp_rd || vecs[i].exp_wr)
        chk($sformatf("row%0d_addr", i), mem_address, vecs[i].exp_addr);
      if (vecs[i].exp_wr)
        chk($sformatf("row%0d_wdata", i), mem_writedata, vecs[i].exp_wd);
      if (i == 5)
        chk("read_line", cache_readdata, RD_LINE);
      step();
    end
    chk("read_line_held_after_write", cache_readdata, RD_LINE);

    // Round-robin from a fresh pointer: caches 0,2,3 request continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("rr_reset");
    cache_address[0] = 32'h0000_0100;
    cache_address[2] = 32'h0000_0200;
    cache_address[3] = 32'h0000_0300;
    cache_read = 4'b1101;
    for (int k = 0; k < 6; k++) begin
      steps = 0;
      while (&cache_waitrequest && steps < 20) begin
        step();
        steps++;
      end
      chk($sformatf("rr%0d_in_time", k), steps < 20, 1'b1);
      chk($sformatf("rr%0d_single", k), $countones(~cache_waitrequest), 1);
      g = 0;
      for (int b = 3; b >= 0; b--) if (!cache_waitrequest[b]) g = b;
      chk($sformatf("rr%0d_grant", k), g, exp_g[k]);
      if (k == 5) cache_read = '0;
      step();
    end
    step();

    // Reset in the middle of a read, after beat 1 has completed
    cache_read = 4'b0010;
    #1;
    step();
    step();
    step();
    chk("mid_beat2_addr", mem_address, 32'h1238);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cache_read = '0;
    #1;
    chk_idle_outputs("mid_reset");
    cache_address[3] = 32'h0000_3000;
    cache_read = 4'b1000;
    step();
    chk("restart_mem_read", mem_read, 1'b1);
    chk("restart_addr", mem_address, 32'h3000);
    wait_done(3, steps);
    chk("restart_done_steps", steps, 4);
    chk("restart_wreq", cache_waitrequest, 4'b0111);
    chk("restart_line", cache_readdata, RD_LINE);
    cache_read = '0;
    step();

    // Low address bits are ignored
    cache_address[2] = 32'h0000_123F;
    cache_read = 4'b0100;
    #1;
    chk("lowbits_idle_wreq", cache_waitrequest, 4'hF);
    step();
    chk("lowbits_addr", mem_address, 32'h1230);
    chk("lowbits_mem_read", mem_read, 1'b1);
    wait_done(2, steps);
    chk("lowbits_done_steps", steps, 4);
    chk("lowbits_wreq", cache_waitrequest, 4'b1011);
    cache_read = '0;
    step();
    chk_idle_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
